// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler
//   Collects a fixed-length frame of UART bytes that starts with the two-byte
//   header HEADER0 HEADER1. The header bytes are kept in the frame. Each
//   completed frame is presented on oData with a single-cycle oDataValid strobe.
//   A partial frame is dropped if the gap between bytes becomes too long, and
//   oTimeout then pulses for one cycle.
//
// Ports
//   iClk        clock; all logic runs on its rising edge
//   iRst_n      asynchronous active-low reset
//   iByte       received byte
//   iByteValid  one-cycle strobe that qualifies iByte
//   oData       last completed frame; the first byte is at the MSBs
//   oDataValid  one-cycle strobe, one cycle after the final byte of a frame
//   oBusy       high while a header or payload is being collected
//   oTimeout    one-cycle strobe when a partial frame is aborted
module uart_frame_assembler #(
  parameter int unsigned PACKAGE_SIZE   = 16,
  parameter int unsigned STREAM_SIZE    = 128,
  parameter logic [7:0]  HEADER0        = 8'hFF,
  parameter logic [7:0]  HEADER1        = 8'hFA,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic                   iClk,
  input  logic                   iRst_n,
  input  logic [7:0]             iByte,
  input  logic                   iByteValid,
  output logic [STREAM_SIZE-1:0] oData,
  output logic                   oDataValid,
  output logic                   oBusy,
  output logic                   oTimeout
);

  localparam int unsigned CW = $clog2(PACKAGE_SIZE);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(PACKAGE_SIZE - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } state_t;

  state_t                 state;
  logic [CW-1:0]          byte_cnt;
  logic [TW-1:0]          idle_cnt;
  logic [STREAM_SIZE-1:0] shift_reg;
  logic [STREAM_SIZE-1:0] shift_nxt;

  // The shift register holds the most recent accepted bytes. When the frame
  // completes, it holds exactly the PACKAGE_SIZE frame bytes. Any older bytes,
  // such as a redundant HEADER0 seen during resync, have been shifted out.
  assign shift_nxt = {shift_reg[STREAM_SIZE-9:0], iByte};

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state      <= IDLE;
      byte_cnt   <= '0;
      idle_cnt   <= '0;
      shift_reg  <= '0;
      oData      <= '0;
      oDataValid <= 1'b0;
      oBusy      <= 1'b0;
      oTimeout   <= 1'b0;
    end else begin
      oDataValid <= 1'b0;
      oTimeout   <= 1'b0;

      if (iByteValid) begin
        idle_cnt <= '0;
      end else if (state != IDLE && idle_cnt != TMAX) begin
        idle_cnt <= idle_cnt + TW'(1);
      end

      // A byte strobe takes priority over a timeout in the same cycle.
      if (iByteValid) begin
        unique case (state)
          IDLE: begin
            if (iByte == HEADER0) begin
              shift_reg <= shift_nxt;
              state     <= HDR;
              oBusy     <= 1'b1;
            end
          end
          HDR: begin
            shift_reg <= shift_nxt;
            if (iByte == HEADER1) begin
              state    <= PAYLOAD;
              byte_cnt <= CW'(2);
            end else if (iByte != HEADER0) begin
              state <= IDLE;
              oBusy <= 1'b0;
            end
          end
          PAYLOAD: begin
            shift_reg <= shift_nxt;
            if (byte_cnt == LAST_IDX) begin
              oData      <= shift_nxt;
              oDataValid <= 1'b1;
              state      <= IDLE;
              oBusy      <= 1'b0;
              byte_cnt   <= '0;
            end else begin
              byte_cnt <= byte_cnt + CW'(1);
            end
          end
          default: begin
            state <= IDLE;
            oBusy <= 1'b0;
          end
        endcase
      end else if (state != IDLE && idle_cnt == TMAX) begin
        state    <= IDLE;
        oBusy    <= 1'b0;
        oTimeout <= 1'b1;
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: doc/uart_frame_assembler.md
UART_FRAME_ASSEMBLER -- requirements
Module: uart_frame_assembler

Interface
REQ-001 SHALL have parameter PACKAGE_SIZE, default 16: frame length in bytes, header included.
REQ-002 SHALL have parameter STREAM_SIZE, default 128: output width, always PACKAGE_SIZE*8.
REQ-003 SHALL have parameter HEADER0, default 8'hFF: first header byte.
REQ-004 SHALL have parameter HEADER1, default 8'hFA: second header byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 50000: maximum idle gap between bytes inside a frame.
REQ-006 SHALL have port iClk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port iRst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 SHALL have port iByte, input, 8 bits: received UART byte.
REQ-009 SHALL have port iByteValid, input, 1 bit: one-cycle strobe, iByte valid.
REQ-010 SHALL have port oData, output, STREAM_SIZE bits: assembled frame, first byte at MSBs; feeds Crc16 iData.
REQ-011 SHALL have port oDataValid, output, 1 bit: one-cycle strobe, new frame on oData; feeds Crc16 iDataValid.
REQ-012 SHALL have port oBusy, output, 1 bit: high while the state is HDR or PAYLOAD.
REQ-013 SHALL have port oTimeout, output, 1 bit: one-cycle strobe, frame aborted by inter-byte timeout.

Function
REQ-014 SHALL implement states IDLE, HDR and PAYLOAD.
REQ-015 SHALL, in IDLE, go to HDR on iByteValid with iByte==HEADER0, and otherwise ignore bytes.
REQ-016 SHALL, in HDR on iByteValid, go to PAYLOAD if iByte==HEADER1, stay in HDR if iByte==HEADER0 (FF FF FA resyncs), and otherwise go to IDLE.
REQ-017 SHALL keep a byte counter, 0..PACKAGE_SIZE-1, sized by $clog2(PACKAGE_SIZE); the counter is 2 on entry to PAYLOAD and increments on each accepted byte.
REQ-018 SHALL shift each accepted byte into a STREAM_SIZE shift register from the LSB side, MSB-first order, with both header bytes included.
REQ-019 SHALL, on the byte that makes PACKAGE_SIZE bytes, load the full register into oData and go to IDLE.
REQ-020 SHALL assert oDataValid for exactly one cycle, in the cycle after that final iByteValid (latency 1).
REQ-021 SHALL hold oData stable from that load until the next frame completes; aborted frames never change oData.
REQ-022 SHALL reload an inter-byte counter to 0 on every iByteValid.
REQ-023 SHALL increment the inter-byte counter each cycle in HDR or PAYLOAD, saturating at TIMEOUT_CYCLES.
REQ-024 SHALL, when the inter-byte counter reaches TIMEOUT_CYCLES in HDR or PAYLOAD, go to IDLE, pulse oTimeout for one cycle and discard the partial frame.
REQ-025 SHALL let iByteValid win over a timeout in the same cycle: the byte is accepted and the timeout is not raised.
REQ-026 SHALL process a byte arriving in the cycle oDataValid is high in IDLE normally, so back-to-back frames lose no bytes.
REQ-027 SHALL give a header byte inside PAYLOAD no special meaning: it is stored as data.
REQ-028 SHALL require no flow control: the downstream Crc16 consumes oData within PACKAGE_SIZE byte times.

Reset
REQ-029 SHALL, while iRst_n is low, immediately force state IDLE, oData=0, oDataValid=0, oBusy=0, oTimeout=0, and clear the shift register, byte counter and inter-byte counter.
REQ-030 SHALL, on reset asserted mid-frame, discard the partial frame; after release, the first frame is assembled only from a fresh HEADER0.

Verification
REQ-031 SHALL cover a valid frame: FF FA then 14 bytes 01..0E -> one oDataValid pulse, 1 cycle after the last strobe; oData=128'hFFFA0102030405060708090A0B0C0D0E.
REQ-032 SHALL cover resync: bytes 00 FF FF FA plus 14 payload bytes -> one frame with oData[127:112]=16'hFFFA; the leading 00 and extra FF are dropped.
REQ-033 SHALL cover a bad header: FF 55 then a valid frame -> exactly one oDataValid, for the valid frame only; oBusy drops after 55.
REQ-034 SHALL cover timeout: FF FA plus 5 bytes, then a gap of TIMEOUT_CYCLES -> oTimeout pulse, state IDLE, oData unchanged, no oDataValid.
REQ-035 SHALL cover reset mid-frame: iRst_n low after byte 8 -> all outputs 0 at once; the next full frame is assembled correctly.
REQ-036 SHALL cover back-to-back frames: two frames with no gap, FF of frame 2 in the oDataValid cycle -> two pulses, both oData values correct.
